scan_chain_ctrl: RTL and testbench

Sequences one scan chain of CHAIN_LEN mux-scan flops (S=1 selects A, the scan input; S=0 selects B, the functional input).

---
 rtl/scan_ctrl_pkg.sv | 15 +
 rtl/scan_resp_cmp.sv | 14 +
 rtl/scan_chain_ctrl.sv | 128 ++++++++++++
 tb/tb_scan_chain_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller.
// State encoding used by scan_chain_ctrl and its variants.
package scan_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    REPORT  = 3'd4
  } state_t;

endpackage

// File: rtl/scan_resp_cmp.sv
// Masked response compare: flags any unmasked bit that differs.
// Purely combinational so multi-chain variants can share it.
module scan_resp_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] RESP,
  input  logic [W-1:0] EXP,
  input  logic [W-1:0] MASK,
  output logic         MISMATCH
);

  assign MISMATCH = |((RESP ^ EXP) & MASK);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload / compare sequencer for one mux-scan chain.
// SE and SI are registered so the chain never sees decode glitches.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic [CHAIN_LEN-1:0] MASK,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 FAIL
);

  state_t state, state_n;

  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]     nxt_idx;
  logic                 last;
  logic                 se_n, si_n;
  logic [CHAIN_LEN-1:0] pat_q, exp_q, mask_q;
  logic                 fail_q;
  logic                 mismatch;

  assign last    = (cnt == CNT_W'(CHAIN_LEN-1));
  // Bit that goes out on the next LOAD cycle, MSB first.
  assign nxt_idx = CNT_W'(CHAIN_LEN-2) - cnt;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    se_n    = 1'b0;
    si_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_n = LOAD;
          cnt_n   = '0;
          se_n    = 1'b1;
          si_n    = PAT[CHAIN_LEN-1];
        end
      end
      LOAD: begin
        if (last) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          se_n  = 1'b1;
          si_n  = pat_q[nxt_idx];
        end
      end
      CAPTURE: begin
        state_n = UNLOAD;
        se_n    = 1'b1;
      end
      UNLOAD: begin
        if (last) begin
          state_n = REPORT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          se_n  = 1'b1;
        end
      end
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      SE    <= 1'b0;
      SI    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      SE    <= se_n;
      SI    <= si_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q  <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      RESP   <= '0;
      fail_q <= 1'b0;
    end else begin
      if (state == IDLE && START) begin
        pat_q  <= PAT;
        exp_q  <= EXP;
        mask_q <= MASK;
      end
      if (state == UNLOAD)
        RESP <= {RESP[CHAIN_LEN-2:0], SO};
      if (state == REPORT)
        fail_q <= mismatch;
    end
  end

  scan_resp_cmp #(
    .W (CHAIN_LEN)
  ) u_cmp (
    .RESP     (RESP),
    .EXP      (exp_q),
    .MASK     (mask_q),
    .MISMATCH (mismatch)
  );

  assign BUSY = (state != IDLE);
  assign DONE = (state == REPORT);
  // Live compare during REPORT, latched copy afterwards.
  assign FAIL = DONE ? mismatch : fail_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: 4-flop and 32-flop behavioural chains with B_i = ~Q_i.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4;
  logic [3:0]  pat4, exp4, mask4;
  logic        se4, si4, so4, busy4, done4, fail4;
  logic [3:0]  resp4;
  logic [3:0]  q4;

  logic        start32;
  logic [31:0] pat32, exp32, mask32;
  logic        se32, si32, so32, busy32, done32, fail32;
  logic [31:0] resp32;
  logic [31:0] q32;

  int checks = 0;
  int errors = 0;

  scan_chain_ctrl #(.CHAIN_LEN(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4),
    .PAT(pat4), .EXP(exp4), .MASK(mask4),
    .SE(se4), .SI(si4), .SO(so4),
    .BUSY(busy4), .DONE(done4),
    .RESP(resp4), .FAIL(fail4)
  );

  scan_chain_ctrl #(.CHAIN_LEN(32)) dut32 (
    .CLK(clk), .RST(rst), .START(start32),
    .PAT(pat32), .EXP(exp32), .MASK(mask32),
    .SE(se32), .SI(si32), .SO(so32),
    .BUSY(busy32), .DONE(done32),
    .RESP(resp32), .FAIL(fail32)
  );

  always @(posedge clk) begin
    if (se4) q4 <= {q4[2:0], si4};
    else     q4 <= ~q4;
  end
  assign so4 = q4[3];

  always @(posedge clk) begin
    if (se32) q32 <= {q32[30:0], si32};
    else      q32 <= ~q32;
  end
  assign so32 = q32[31];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_small(input logic [3:0] p,
                           input logic [3:0] e,
                           input logic [3:0] m,
                           input logic [3:0] r,
                           input logic       f);
    int cyc;
    @(negedge clk);
    chk("idle_busy", busy4, 0);
    pat4 = p; exp4 = e; mask4 = m;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("load_busy", busy4, 1);
    for (int i = 0; i < 4; i++) begin
      chk("load_se", se4, 1);
      chk("load_si", si4, p[3-i]);
      @(negedge clk);
    end
    chk("cap_se", se4, 0);
    chk("cap_si", si4, 0);
    cyc = 5;
    while (!done4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", cyc, 10);
    chk("resp", resp4, r);
    chk("fail", fail4, f);
  endtask

  initial begin
    int n_done;
    int done_cyc;
    int cyc;

    rst = 1'b1;
    start4 = 1'b0; pat4 = '0; exp4 = '0; mask4 = '0;
    start32 = 1'b0; pat32 = '0; exp32 = '0; mask32 = '0;
    repeat (2) @(negedge clk);
    chk("rst_se", se4, 0);
    chk("rst_si", si4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_resp", resp4, 0);
    chk("rst_fail", fail4, 0);
    chk("rst_busy32", busy32, 0);
    rst = 1'b0;

    // Basic run: ~1010 captured
    run_small(4'b1010, 4'b0101, 4'hF, 4'b0101, 1'b0);

    // START during LOAD and UNLOAD is dropped
    @(negedge clk);
    pat4 = 4'b1010; exp4 = 4'b0101; mask4 = 4'hF;
    start4 = 1'b1;
    n_done = 0;
    done_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start4 = (c == 2 || c == 6);
      if (done4) begin
        n_done++;
        done_cyc = c;
      end
    end
    start4 = 1'b0;
    chk("ign_ndone", n_done, 1);
    chk("ign_donecyc", done_cyc, 10);
    chk("ign_resp", resp4, 4'b0101);
    chk("ign_busy", busy4, 0);

    // Masked compare
    run_small(4'b1010, 4'b0111, 4'b1101, 4'b0101, 1'b0);
    run_small(4'b1010, 4'b0111, 4'hF, 4'b0101, 1'b1);
    @(negedge clk);
    chk("fail_hold", fail4, 1);
    chk("idle_done", done4, 0);

    // Reset in UNLOAD cycle 2
    @(negedge clk);
    pat4 = 4'b1010; exp4 = 4'b0101; mask4 = 4'hF;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", busy4, 1);
    chk("pre_rst_se", se4, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_se", se4, 0);
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_resp", resp4, 0);
    chk("mid_rst_fail", fail4, 0);
    chk("mid_rst_done", done4, 0);
    run_small(4'b1010, 4'b0101, 4'hF, 4'b0101, 1'b0);

    // Back-to-back: START on the first IDLE cycle
    run_small(4'b0011, 4'b1100, 4'hF, 4'b1100, 1'b0);

    // 32-flop chain
    @(negedge clk);
    pat32 = 32'hDEADBEEF;
    exp32 = 32'h21524110;
    mask32 = 32'hFFFFFFFF;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("c32_busy", busy32, 1);
    cyc = 1;
    while (!done32 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("c32_done_cycle", cyc, 66);
    chk("c32_resp", resp32, 32'h21524110);
    chk("c32_fail", fail32, 0);
    @(negedge clk);
    chk("c32_idle", busy32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
